// File: rtl/iccm_loader_pkg.sv
// Shared types and defaults for the ICCM UART boot loader.
// State CHECK exists only when ICCM_LOADER_CHECKSUM_EN is defined.
// No logic here: enum, default end marker and default ICCM word-address width.
package iccm_loader_pkg;

    localparam int          ICCM_AW    = 12;
    localparam logic [31:0] END_MARKER = 32'h0000_0FFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
`ifdef ICCM_LOADER_CHECKSUM_EN
        ST_CHECK = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/iccm_word_packer.sv
// Packs UART bytes little-endian into 32-bit words.
// Latency: word_vld_o is combinational with the 4th byte; the word is valid only in that cycle.
// Backpressure: none, every byte_vld_i is consumed; clear_i drops any partial word.
module iccm_word_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_vld_o
);

    logic [1:0]  cnt_q;
    logic [23:0] buf_q;

    // The 4th byte bypasses the buffer so the word is ready in the cycle it arrives.
    assign word_vld_o = byte_vld_i && (cnt_q == 2'd3);
    assign word_o     = {byte_i, buf_q};

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= 2'd0;
            buf_q <= 24'd0;
        end else if (byte_vld_i) begin
            cnt_q <= cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    buf_q[7:0]   <= byte_i;
                2'd1:    buf_q[15:8]  <= byte_i;
                2'd2:    buf_q[23:16] <= byte_i;
                default: buf_q        <= buf_q;
            endcase
        end
    end

endmodule

// File: rtl/iccm_loader.sv
// Loads ICCM from a UART byte stream, holding the core in reset until done (optional ICCM_LOADER_CHECKSUM_EN).
// Latency: we_o rises the cycle after the 4th byte of a word; done_o the cycle after the end marker/checksum.
// Backpressure: none; bytes arriving in DONE are dropped.
module iccm_loader
    import iccm_loader_pkg::*;
#(
    parameter int          AddrW     = ICCM_AW,
    parameter logic [31:0] EndMarker = END_MARKER
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_dv_i,
    input  logic [7:0]       rx_byte_i,
    input  logic             boot_skip_i,
    output logic             we_o,
    output logic [AddrW-1:0] addr_o,
    output logic [31:0]      wdata_o,
    output logic             reset_o,
    output logic             done_o,
    output logic             err_o
);

    state_e             state_q, state_d;
    logic               byte_vld, pk_clear, word_vld;
    logic [31:0]        word;
    logic [AddrW-1:0]   wcnt_q;
    logic               full_q;
    logic               wr_go, ovf;
`ifdef ICCM_LOADER_CHECKSUM_EN
    logic [31:0]        csum_q;
    logic               csum_bad;
`endif

    assign addr_o = wcnt_q;

    iccm_word_packer u_packer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (pk_clear),
        .byte_vld_i (byte_vld),
        .byte_i     (rx_byte_i),
        .word_o     (word),
        .word_vld_o (word_vld)
    );

    always_comb begin
        state_d  = state_q;
        byte_vld = 1'b0;
        pk_clear = 1'b0;
        wr_go    = 1'b0;
        ovf      = 1'b0;
        reset_o  = 1'b1;
        done_o   = 1'b0;
`ifdef ICCM_LOADER_CHECKSUM_EN
        csum_bad = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (boot_skip_i) begin
                    state_d = ST_DONE;
                end else if (rx_dv_i) begin
                    byte_vld = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                byte_vld = rx_dv_i;
                if (word_vld) begin
                    if (word == EndMarker) begin
`ifdef ICCM_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end else if (full_q) begin
                        ovf     = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        wr_go = 1'b1;
                    end
                end
            end
`ifdef ICCM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                byte_vld = rx_dv_i;
                if (word_vld) begin
                    csum_bad = (word != csum_q);
                    state_d  = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                pk_clear = 1'b1;
                reset_o  = 1'b0;
                done_o   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            full_q  <= 1'b0;
            we_o    <= 1'b0;
            wdata_o <= 32'd0;
            err_o   <= 1'b0;
`ifdef ICCM_LOADER_CHECKSUM_EN
            csum_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            we_o    <= wr_go;
            if (wr_go)
                wdata_o <= word;
            // Address advances at the end of the write cycle; full marks the top address as used.
            if (we_o) begin
                wcnt_q <= wcnt_q + AddrW'(1);
                if (&wcnt_q)
                    full_q <= 1'b1;
            end
            if (ovf)
                err_o <= 1'b1;
`ifdef ICCM_LOADER_CHECKSUM_EN
            if (wr_go)
                csum_q <= csum_q + word;
            if (csum_bad)
                err_o <= 1'b1;
`endif
        end
    end

endmodule
